// File: rtl/div_seq.sv
// div_seq: sequential unsigned restoring divider with a shared operand bus.
//
// A division is requested by holding start high in IDLE. The block then asks
// for the dividend (ld_a) and the divisor (ld_b) on data_in, one cycle each,
// runs W shift-subtract steps in CALC and presents the registered result in
// DONE. DONE is held while start stays high, so a level-held start cannot
// trigger a second division.
//
// Handshake: ld_a / ld_b are Moore strobes. While one is high, data_in must
// carry the matching operand, and the operand is captured on the next rising
// edge. data_in is ignored in every other cycle. done is high for every cycle
// spent in DONE; quotient, remainder and div_zero are valid from the first
// done cycle and hold until the next result or reset.
//
// Build option: define DIV_ZERO_CHECK_EN to short-circuit a zero divisor from
// LOAD_B straight to DONE with div_zero=1. Without it a zero divisor runs the
// full CALC sequence and div_zero is tied low.
module div_seq #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] data_in,
   output logic         ld_a,
   output logic         ld_b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_zero
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_CALC   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t state_q, state_d;

   // Dividend shift register; quotient bits enter at the LSB as dividend
   // bits leave at the MSB, so after W steps it holds the quotient.
   logic [W-1:0]  dvd_q, dvd_d;
   logic [W-1:0]  dvs_q, dvs_d;
   // Partial remainder, one bit wider than the operands.
   logic [W:0]    rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Result registers, written only on entry to DONE.
   logic [W-1:0]  quo_q, quo_d;
   logic [W-1:0]  rmd_q, rmd_d;

`ifdef DIV_ZERO_CHECK_EN
   logic          dz_q, dz_d;
   logic          dvs_in_zero;
`endif

   // One restoring step, derived from the current partial remainder.
   logic [W+1:0]  trial;
   logic          step_ge;
   logic [W:0]    step_rem;
   logic [W-1:0]  step_quo;
   logic          last_step;

`ifdef DIV_ZERO_CHECK_EN
   // Zero divisor detection on the bus during LOAD_B.
   assign dvs_in_zero = (data_in == '0);
`endif

   // Restoring shift-subtract step and end-of-count detection.
   always_comb begin
      // Shift the next dividend bit into the remainder, then try the subtract.
      // The extra top bit of trial is the borrow/sign of the subtraction.
      trial     = {rem_q, dvd_q[W-1]} - {2'b00, dvs_q};
      step_ge   = ~trial[W+1];
      step_rem  = step_ge ? trial[W:0] : {rem_q[W-1:0], dvd_q[W-1]};
      step_quo  = {dvd_q[W-2:0], step_ge};
      last_step = (cnt_q == CW'(1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD_A;
            end
         end
         S_LOAD_A: begin
            state_d = S_LOAD_B;
         end
         S_LOAD_B: begin
`ifdef DIV_ZERO_CHECK_EN
            state_d = dvs_in_zero ? S_DONE : S_CALC;
`else
            state_d = S_CALC;
`endif
         end
         S_CALC: begin
            if (last_step) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Leave only once start has been seen low.
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore output decode.
   always_comb begin
      ld_a = 1'b0;
      ld_b = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_LOAD_A: begin
            ld_a = 1'b1;
            busy = 1'b1;
         end
         S_LOAD_B: begin
            ld_b = 1'b1;
            busy = 1'b1;
         end
         S_CALC: begin
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Datapath next-state: operand capture, stepping and result load.
   always_comb begin
      dvd_d = dvd_q;
      dvs_d = dvs_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      quo_d = quo_q;
      rmd_d = rmd_q;
`ifdef DIV_ZERO_CHECK_EN
      dz_d  = dz_q;
`endif
      case (state_q)
         S_LOAD_A: begin
            dvd_d = data_in;
         end
         S_LOAD_B: begin
            dvs_d = data_in;
            rem_d = '0;
            cnt_d = CW'(W);
`ifdef DIV_ZERO_CHECK_EN
            // Zero divisor: publish the defined result directly.
            if (dvs_in_zero) begin
               quo_d = '1;
               rmd_d = dvd_q;
               dz_d  = 1'b1;
            end
`endif
         end
         S_CALC: begin
            dvd_d = step_quo;
            rem_d = step_rem;
            cnt_d = cnt_q - CW'(1);
            // Final step lands straight in the result registers.
            if (last_step) begin
               quo_d = step_quo;
               rmd_d = step_rem[W-1:0];
`ifdef DIV_ZERO_CHECK_EN
               dz_d  = 1'b0;
`endif
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath and result registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q <= '0;
         dvs_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         quo_q <= '0;
         rmd_q <= '0;
`ifdef DIV_ZERO_CHECK_EN
         dz_q  <= 1'b0;
`endif
      end else begin
         dvd_q <= dvd_d;
         dvs_q <= dvs_d;
         rem_q <= rem_d;
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rmd_q <= rmd_d;
`ifdef DIV_ZERO_CHECK_EN
         dz_q  <= dz_d;
`endif
      end
   end

   assign quotient  = quo_q;
   assign remainder = rmd_q;
`ifdef DIV_ZERO_CHECK_EN
   assign div_zero  = dz_q;
`else
   assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized scoreboard bench for div_seq (W=16).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled on
// the falling edge by the monitor. Honors DIV_ZERO_CHECK_EN like the design.
module tb_div_seq;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] data_in;
   logic         ld_a;
   logic         ld_b;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   div_seq #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (data_in),
      .ld_a      (ld_a),
      .ld_b      (ld_b),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic end_req = 1'b0;

   // Reference: plain unsigned arithmetic plus the zero-divisor rules.
   function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q = '1;
         e.r = a;
`ifdef DIV_ZERO_CHECK_EN
         e.z   = 1'b1;
         e.lat = 1;
`else
         e.z   = 1'b0;
         e.lat = W + 1;
`endif
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.z   = 1'b0;
         e.lat = W + 1;
      end
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // hold: extra DONE cycles with start kept high; abort_at: CALC cycle
   // in which reset is pulsed (negative = run to completion).
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input int abort_at);
      int guard;
      step();
      start   = 1'b1;
      data_in = W'($urandom);
      guard   = 0;
      while (!ld_a && guard < 20) begin
         step();
         data_in = W'($urandom);
         guard++;
      end
      data_in = a;
      if (abort_at < 0) exp_q.push_back(ref_div(a, b));
      step();
      data_in = b;
      if (hold == 0) start = 1'b0;
      step();
      data_in = W'($urandom);
      if (abort_at > 0) begin
         repeat (abort_at - 1) begin
            step();
            data_in = W'($urandom);
         end
         rst = 1'b1;
         step();
         rst = 1'b0;
         return;
      end
      guard = 0;
      while (!done && guard < W + 10) begin
         step();
         data_in = W'($urandom);
         guard++;
      end
      repeat (hold) begin
         step();
         data_in = W'($urandom);
      end
      start = 1'b0;
      guard = 0;
      step();
      while (done && guard < 10) begin
         step();
         guard++;
      end
   endtask

   // ---------------- monitor ----------------
   logic [W-1:0] hold_q = '0;
   logic [W-1:0] hold_r = '0;
   logic         hold_z = 1'b0;
   logic         p_rst  = 1'b1;
   logic         p_idle = 1'b1;
   logic         p_start = 1'b0;
   logic         p_ld_a = 1'b0;
   logic         p_done = 1'b0;
   logic         in_calc = 1'b0;
   int           lat = 0;
   exp_t         e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (p_rst) begin
         chk("rst_ld_a", 32'(ld_a), 32'd0);
         chk("rst_ld_b", 32'(ld_b), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_quotient", 32'(quotient), 32'd0);
         chk("rst_remainder", 32'(remainder), 32'd0);
         chk("rst_div_zero", 32'(div_zero), 32'd0);
         hold_q  = '0;
         hold_r  = '0;
         hold_z  = 1'b0;
         in_calc = 1'b0;
         lat     = 0;
      end else begin
         if (in_calc) lat++;
         chk("ld_a", 32'(ld_a), 32'(p_idle && p_start));
         chk("ld_b", 32'(ld_b), 32'(p_ld_a));
         if (p_done) chk("done_hold", 32'(done), 32'(p_start));
         if (done && !p_done) begin
            chk("done_expected", 32'(in_calc), 32'd1);
            if (exp_q.size() == 0) begin
               chk("exp_queue_empty", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("quotient", 32'(quotient), 32'(e.q));
               chk("remainder", 32'(remainder), 32'(e.r));
               chk("div_zero", 32'(div_zero), 32'(e.z));
               chk("done_latency", 32'(lat), 32'(e.lat));
               hold_q = e.q;
               hold_r = e.r;
               hold_z = e.z;
            end
            in_calc = 1'b0;
         end
         chk("busy", 32'(busy), 32'(ld_a || ld_b || in_calc));
         chk("hold_quotient", 32'(quotient), 32'(hold_q));
         chk("hold_remainder", 32'(remainder), 32'(hold_r));
         chk("hold_div_zero", 32'(div_zero), 32'(hold_z));
         chk("onehot", 32'($countones({ld_a, ld_b, done}) <= 1), 32'd1);
         if (in_calc && lat > W + 2) begin
            chk("done_timeout", 32'(lat), 32'(W + 1));
            in_calc = 1'b0;
         end
         if (ld_b) begin
            in_calc = 1'b1;
            lat     = 0;
         end
      end
      p_rst   = rst;
      p_idle  = !busy && !done;
      p_start = start;
      p_ld_a  = ld_a;
      p_done  = done;
      if (end_req) begin
         chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
         $finish;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           r;
      rst     = 1'b1;
      start   = 1'b0;
      data_in = '0;
      repeat (3) step();
      rst = 1'b0;
      repeat (2) step();

      do_div(W'(100), W'(7), 0, -1);
      do_div(W'(25), W'(4), 0, -1);
      do_div(W'(16'hFFFF), W'(1), 0, -1);
      do_div(W'(5), W'(9), 0, -1);
      do_div(W'(0), W'(3), 0, -1);
      do_div(W'(42), W'(0), 0, -1);
      do_div(W'(100), W'(7), 10, -1);
      do_div(W'(100), W'(7), 0, 8);
      repeat (2) step();
      do_div(W'(100), W'(7), 0, -1);
      do_div(W'(1), W'(16'hFFFF), 2, -1);

      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         r = $urandom_range(0, 7);
         if (r == 0)     b = '0;
         else if (r < 4) b = W'($urandom_range(1, 255));
         else            b = W'($urandom);
         do_div(a, b, $urandom_range(0, 3), -1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      end

      repeat (3) step();
      end_req = 1'b1;
   end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter W, default 16: operand, quotient and remainder width; legal values 4..32.
REQ-002 clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on posedge clk.
REQ-004 start  input  1  level request to begin a division; sampled on posedge clk.
REQ-005 data_in  input  W  shared operand bus: dividend, then divisor.
REQ-006 ld_a  output  1  high for exactly one cycle while the dividend is expected on data_in.
REQ-007 ld_b  output  1  high for exactly one cycle while the divisor is expected on data_in.
REQ-008 busy  output  1  high in LOAD_A, LOAD_B and CALC.
REQ-009 done  output  1  high in DONE only.
REQ-010 quotient  output  W  result quotient; registered.
REQ-011 remainder  output  W  result remainder; registered.
REQ-012 div_zero  output  1  divide-by-zero flag; registered.

Function
REQ-013 FSM states SHALL be IDLE, LOAD_A, LOAD_B, CALC and DONE, with all outputs decoded from state (Moore).
REQ-014 IDLE -> LOAD_A on a posedge with start=1; otherwise remain in IDLE.
REQ-015 LOAD_A: ld_a=1; next posedge captures data_in as dividend -> LOAD_B, regardless of start.
REQ-016 LOAD_B: ld_b=1; next posedge (edge Eb) captures data_in as divisor, clears partial remainder, loads step counter with W -> CALC.
REQ-017 CALC: one restoring shift-subtract step per cycle, MSB of dividend first; partial remainder is W+1 bits wide; quotient bit = 1 when the trial subtraction is non-negative, else restore.
REQ-018 Transition CALC -> DONE on edge Eb+W; done first high in the cycle after Eb+W (W+1 edges after ld_b falls, counting Eb).
REQ-019 quotient, remainder and div_zero SHALL update only on entry to DONE and hold stable until the next entry to DONE or reset.
REQ-020 DONE: remain while start=1; DONE -> IDLE on the first posedge with start=0.
REQ-021 A start held high through DONE SHALL NOT begin a new division; start must be seen low (return to IDLE) before the next start.
REQ-022 data_in SHALL be ignored in every state except LOAD_A and LOAD_B.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor, unsigned.
REQ-024 Exactly one of ld_a, ld_b, done, or none, SHALL be high in any cycle.

Reset
REQ-025 rst=1 at a posedge SHALL force IDLE and clear quotient, remainder, div_zero, the counter and the internal registers to 0, overriding start and any state.
REQ-026 Reset asserted mid-CALC SHALL abort the division with no partial result visible; the next start then runs a complete fresh sequence.
REQ-027 After reset: ld_a=ld_b=busy=done=div_zero=0, quotient=remainder=0.

Configuration
REQ-028 Macro DIV_ZERO_CHECK_EN: when defined, a zero divisor captured at Eb SHALL go LOAD_B -> DONE directly, setting quotient=all ones, remainder=dividend, div_zero=1, with done high in the cycle after Eb.
REQ-029 When DIV_ZERO_CHECK_EN is undefined, a zero divisor SHALL run the full W-cycle CALC (yielding quotient=all ones, remainder=dividend), and div_zero SHALL be tied 0.
REQ-030 A nonzero divisor SHALL clear div_zero on entry to DONE in both builds.

Verification (W=16)
REQ-031 dividend 100, divisor 7 -> quotient 14, remainder 2, div_zero 0; done high in the cycle after Eb+16.
REQ-032 Back-to-back divisions 25/4 and then 0xFFFF/1 with start dropped between them -> 6 r1, then 0xFFFF r0; ld_a/ld_b each pulse exactly once per division.
REQ-033 dividend 5, divisor 9 -> quotient 0, remainder 5; 0/3 -> quotient 0, remainder 0.
REQ-034 Divisor 0, dividend 42: with macro -> done in the cycle after Eb, quotient 0xFFFF, remainder 42, div_zero 1; without macro -> same quotient and remainder at Eb+16, div_zero 0.
REQ-035 rst pulsed during the 8th CALC cycle -> IDLE next cycle, all outputs 0; a following 100/7 returns 14 r2.
REQ-036 start held high through DONE for 10 cycles -> no ld_a pulse until start is low for at least one edge.
